// File: rtl/sine_pwm_pkg.sv
// Shared definitions for the sine PWM output stage: parameter legality,
// residual width and duty saturation.
package sine_pwm_pkg;

  localparam int unsigned DEF_PRECISION = 4;
  localparam int unsigned DEF_PWM_BITS  = 4;
  localparam int unsigned DEF_PRESCALE  = 1;

  function automatic bit params_legal(input int unsigned precision,
                                      input int unsigned pwm_bits,
                                      input int unsigned prescale);
    return (pwm_bits >= 1) && (pwm_bits <= precision) && (prescale >= 1);
  endfunction

  // Bits dropped when a sample is narrowed to a duty value.
  function automatic int unsigned res_width(input int unsigned precision,
                                            input int unsigned pwm_bits);
    return precision - pwm_bits;
  endfunction

  function automatic logic [31:0] sat_duty(input logic [31:0] val,
                                           input int unsigned bits);
    logic [31:0] max_v;
    max_v = (32'd1 << bits) - 32'd1;
    return (val > max_v) ? max_v : val;
  endfunction

endpackage

// File: rtl/sine_pwm_dac_if.sv
// Sample stream handshake between the sine generator and the PWM output stage.
interface sine_pwm_dac_if
  import sine_pwm_pkg::*;
#(
  parameter int unsigned PRECISION = DEF_PRECISION
);
  logic [PRECISION-1:0] sample_in;
  logic                 sample_valid;
  logic                 sample_ready;

  modport master (output sample_in, output sample_valid, input sample_ready);
  modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/tick_prescaler.sv
// Step strobe generator: tick is high once every PRESCALE clk cycles.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sine_pwm_dac.sv
// Sample stream to single-bit PWM with frame-aligned duty updates.
// Define SINE_PWM_ERRFB_EN for first-order error feedback on the dropped LSBs.
module sine_pwm_dac
  import sine_pwm_pkg::*;
#(
  parameter int unsigned PRECISION = DEF_PRECISION,
  parameter int unsigned PWM_BITS  = DEF_PWM_BITS,
  parameter int unsigned PRESCALE  = DEF_PRESCALE
) (
  input  logic           clk,
  input  logic           rst,
  sine_pwm_dac_if.slave  s_if,
  output logic           pwm_out,
  output logic           frame_start,
  output logic           underrun
);
  localparam int unsigned RES_W = res_width(PRECISION, PWM_BITS);
  localparam int unsigned EXT_W = PRECISION + 1;
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  if (!params_legal(PRECISION, PWM_BITS, PRESCALE)) begin : g_bad_params
    $error("sine_pwm_dac: illegal PRECISION/PWM_BITS/PRESCALE combination");
  end

  logic                 tick;
  logic                 boundary, accept, load;
  logic [PWM_BITS-1:0]  cnt_q, cnt_d, duty_q, duty_d, load_duty;
  logic [PRECISION-1:0] pend_q, pend_d;
  logic                 pend_full_q, pend_full_d;
  logic                 pwm_q, pwm_d, fs_q, fs_d, ur_q, ur_d;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign s_if.sample_ready = ~pend_full_q;
  assign boundary = tick && (cnt_q == CNT_MAX);
  assign accept   = s_if.sample_valid && ~pend_full_q;
  assign load     = boundary && pend_full_q;

`ifdef SINE_PWM_ERRFB_EN
  if (RES_W > 0) begin : g_errfb
    logic [RES_W-1:0] res_q;
    logic [EXT_W-1:0] ext;
    assign ext       = {1'b0, pend_q} + EXT_W'(res_q);
    assign load_duty = PWM_BITS'(sat_duty(32'(ext >> RES_W), PWM_BITS));
    // Residual only advances when a sample is actually consumed.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)       res_q <= '0;
      else if (load) res_q <= ext[RES_W-1:0];
    end
  end else begin : g_trunc
    assign load_duty = pend_q[PRECISION-1 -: PWM_BITS];
  end
`else
  assign load_duty = pend_q[PRECISION-1 -: PWM_BITS];
`endif

  always_comb begin
    cnt_d       = tick ? cnt_q + PWM_BITS'(1) : cnt_q;
    pend_d      = accept ? s_if.sample_in : pend_q;
    pend_full_d = pend_full_q;
    if (load)   pend_full_d = 1'b0;
    if (accept) pend_full_d = 1'b1;
    duty_d      = load ? load_duty : duty_q;
    // Compare against the post-update count/duty so output aligns with frame_start.
    pwm_d       = (cnt_d < duty_d);
    fs_d        = boundary;
    ur_d        = boundary && ~pend_full_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      duty_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      pwm_q       <= 1'b0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      pwm_q       <= pwm_d;
      fs_q        <= fs_d;
      ur_q        <= ur_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;
endmodule

// File: tb/tb_sine_pwm_dac.sv
// Scoreboard bench for sine_pwm_dac (PRECISION=8, PWM_BITS=4, PRESCALE=2).
module tb_sine_pwm_dac;
  localparam int unsigned PREC  = 8;
  localparam int unsigned PWMB  = 4;
  localparam int unsigned PRESC = 2;
  localparam int FRAME = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm_out, frame_start, underrun;

  sine_pwm_dac_if #(.PRECISION(PREC)) bus ();

  sine_pwm_dac #(.PRECISION(PREC), .PWM_BITS(PWMB), .PRESCALE(PRESC)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_if        (bus),
    .pwm_out     (pwm_out),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] send_q[$];
  int exp_q[$];
  int unsigned m_res, m_duty;
  int fr_highs, fr_fsmid, fr_acc_n, fr_acc_c, fr_stall;
  bit fr_fs, fr_ur;

  // Reference duty for a loaded sample (PWM_BITS=4 out of 8-bit samples).
  function automatic int unsigned model_load(input logic [7:0] s);
    int unsigned v;
`ifdef SINE_PWM_ERRFB_EN
    v = 32'(s) + m_res;
    m_res = v % 16;
    v = v / 16;
    if (v > 15) v = 15;
`else
    v = 32'(s) / 16;
`endif
    return v;
  endfunction

  task automatic send(input logic [7:0] s);
    send_q.push_back(s);
    m_duty = model_load(s);
    exp_q.push_back(2 * int'(m_duty));
  endtask

  task automatic hold();
    exp_q.push_back(2 * int'(m_duty));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_in = '0;
    send_q.delete();
    exp_q.delete();
    m_res = 0;
    m_duty = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(0);
  endtask

  task automatic wait_fs(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (frame_start) begin
        n = i;
        break;
      end
    end
  endtask

  // Runs one frame from a frame_start negedge to the next, feeding send_q.
  task automatic run_frame();
    bit rdy;
    fr_highs = 0; fr_fsmid = 0; fr_acc_n = 0; fr_acc_c = -1; fr_stall = 0;
    for (int c = 0; c < FRAME; c++) begin
      fr_highs += int'(pwm_out);
      if (c > 0 && frame_start) fr_fsmid++;
      if (send_q.size() > 0) begin
        bus.sample_valid = 1'b1;
        bus.sample_in = send_q[0];
      end else begin
        bus.sample_valid = 1'b0;
      end
      rdy = bus.sample_ready;
      if (bus.sample_valid && !rdy) fr_stall++;
      if (bus.sample_valid && rdy) begin
        void'(send_q.pop_front());
        fr_acc_n++;
        fr_acc_c = c;
      end
      @(negedge clk);
    end
    if (send_q.size() == 0) bus.sample_valid = 1'b0;
    fr_fs = frame_start;
    fr_ur = underrun;
  endtask

  task automatic test_reset();
    int n;
    apply_reset();
    #1;
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs: got %b want 0", frame_start); end
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL reset_ur: got %b want 0", underrun); end
    n_cmp++; if (bus.sample_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.sample_ready); end
    wait_fs(n);
    n_cmp++; if (n !== 32) begin n_bad++; $display("FAIL reset_first_fs: got %0d cycles want 32", n); end
    n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL reset_first_ur: got %b want 1", underrun); end
  endtask

  task automatic test_single();
    int n, e;
    apply_reset();
    wait_fs(n);
    send(8'h80);
    run_frame();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    n_cmp++; if (fr_highs !== e) begin n_bad++; $display("FAIL single_f0_highs: got %0d want %0d", fr_highs, e); end
    n_cmp++; if (fr_ur !== 1'b0) begin n_bad++; $display("FAIL single_f0_ur: got %b want 0", fr_ur); end
    for (int f = 1; f <= 2; f++) begin
      hold();
      run_frame();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      n_cmp++; if (fr_highs !== e) begin n_bad++; $display("FAIL single_f%0d_highs: got %0d want %0d", f, fr_highs, e); end
      n_cmp++; if (fr_fs !== 1'b1 || fr_fsmid !== 0) begin n_bad++; $display("FAIL single_f%0d_period: fs_end %b mid %0d want 1/0", f, fr_fs, fr_fsmid); end
    end
  endtask

  task automatic test_zero_full();
    int n, e;
    apply_reset();
    wait_fs(n);
    for (int f = 0; f < 3; f++) begin
      if (f == 0) send(8'h00);
      else if (f == 1) send(8'hFF);
      else hold();
      run_frame();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      n_cmp++; if (fr_highs !== e) begin n_bad++; $display("FAIL zf_f%0d_highs: got %0d want %0d", f, fr_highs, e); end
    end
  endtask

  task automatic test_back_to_back();
    int n, e;
    apply_reset();
    wait_fs(n);
    send(8'h40);
    send(8'hC0);
    run_frame();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    n_cmp++; if (fr_highs !== e) begin n_bad++; $display("FAIL b2b_f0_highs: got %0d want %0d", fr_highs, e); end
    n_cmp++; if (fr_acc_n !== 1 || fr_acc_c !== 0) begin n_bad++; $display("FAIL b2b_f0_accept: got n=%0d c=%0d want 1/0", fr_acc_n, fr_acc_c); end
    n_cmp++; if (fr_stall !== 31) begin n_bad++; $display("FAIL b2b_f0_stall: got %0d want 31", fr_stall); end
    run_frame();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    n_cmp++; if (fr_highs !== e) begin n_bad++; $display("FAIL b2b_f1_highs: got %0d want %0d", fr_highs, e); end
    n_cmp++; if (fr_acc_n !== 1 || fr_acc_c !== 0) begin n_bad++; $display("FAIL b2b_f1_accept: got n=%0d c=%0d want 1/0", fr_acc_n, fr_acc_c); end
    n_cmp++; if (fr_ur !== 1'b0) begin n_bad++; $display("FAIL b2b_f1_ur: got %b want 0", fr_ur); end
    hold();
    run_frame();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    n_cmp++; if (fr_highs !== e) begin n_bad++; $display("FAIL b2b_f2_highs: got %0d want %0d", fr_highs, e); end
  endtask

  task automatic test_underrun();
    int n, e;
    apply_reset();
    wait_fs(n);
    send(8'hA0);
    run_frame();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    n_cmp++; if (fr_ur !== 1'b0) begin n_bad++; $display("FAIL ur_f0_flag: got %b want 0", fr_ur); end
    for (int f = 1; f <= 3; f++) begin
      hold();
      run_frame();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      n_cmp++; if (fr_highs !== e) begin n_bad++; $display("FAIL ur_f%0d_highs: got %0d want %0d", f, fr_highs, e); end
      n_cmp++; if (fr_ur !== 1'b1) begin n_bad++; $display("FAIL ur_f%0d_flag: got %b want 1", f, fr_ur); end
    end
  endtask

  task automatic test_errfb();
    int n, e;
    apply_reset();
    wait_fs(n);
    for (int f = 0; f < 5; f++) begin
      send(8'h08);
      run_frame();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      n_cmp++; if (fr_highs !== e) begin n_bad++; $display("FAIL errfb_f%0d_highs: got %0d want %0d", f, fr_highs, e); end
    end
  endtask

  task automatic test_reset_mid();
    int n, e;
    apply_reset();
    wait_fs(n);
    send(8'h80);
    run_frame();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    // Now at the start of a duty-8 frame; park a sample in pending.
    bus.sample_in = 8'hFF;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    n_cmp++; if (bus.sample_ready !== 1'b0) begin n_bad++; $display("FAIL mid_pending_full: ready %b want 0", bus.sample_ready); end
    repeat (9) @(negedge clk);
    n_cmp++; if (pwm_out !== 1'b1) begin n_bad++; $display("FAIL mid_pwm_before: got %b want 1", pwm_out); end
    rst = 1'b1;
    #1;
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL mid_pwm_in_reset: got %b want 0", pwm_out); end
    n_cmp++; if (bus.sample_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready_in_reset: got %b want 1", bus.sample_ready); end
    apply_reset();
    #1;
    n_cmp++; if (bus.sample_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready_release: got %b want 1", bus.sample_ready); end
    wait_fs(n);
    n_cmp++; if (n !== 32 || underrun !== 1'b1) begin n_bad++; $display("FAIL mid_first_fs: got %0d cycles ur %b want 32/1", n, underrun); end
    hold();
    run_frame();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    n_cmp++; if (fr_highs !== e) begin n_bad++; $display("FAIL mid_after_highs: got %0d want %0d", fr_highs, e); end
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_in = '0;
    test_reset();
    test_single();
    test_zero_full();
    test_back_to_back();
    test_underrun();
    test_errfb();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sine_pwm_dac.md
# sine_pwm_dac

Output stage for the sine wave generator: converts its unsigned sample stream into a single-bit PWM waveform that drives an LED or buzzer pin through an RC filter. Accepts samples over a valid/ready handshake into a one-deep pending buffer. Loads a new duty cycle only at PWM frame boundaries, so every frame is glitch-free. Flags frames that had no fresh sample.

## Interface
- PRECISION, 4, width of incoming unsigned sample.
- PWM_BITS, 4, PWM counter/duty width; must satisfy 1 ≤ PWM_BITS ≤ PRECISION.
- PRESCALE, 1, clk cycles per PWM counter step; ≥ 1.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- sample_in  in  PRECISION  unsigned sample.
- sample_valid  in  1  sample_in is valid; free-running producers tie high.
- sample_ready  out  1  pending buffer empty; equals ~pending_full (combinational).
- pwm_out  out  1  registered PWM output.
- frame_start  out  1  one-cycle pulse at the first step of every frame.
- underrun  out  1  one-cycle pulse when a frame boundary finds the pending buffer empty.

## Operation
- Prescaler: counts 0..PRESCALE-1 and asserts `tick` on PRESCALE-1, then wraps. With PRESCALE=1, `tick` is asserted every cycle.
- pwm_cnt (PWM_BITS): increments on `tick` and wraps from 2^PWM_BITS-1 to 0.
- Frame boundary: `tick` while pwm_cnt == 2^PWM_BITS-1.
- Accept: when sample_valid && sample_ready, the sample is written to pending and pending_full is set.
- At a frame boundary:
  - If pending_full: duty is loaded from pending and pending_full is cleared.
  - Otherwise: duty holds its value and underrun pulses.
- Accept and boundary in the same cycle with pending empty: the sample goes to pending and is used at the next boundary. underrun still pulses.
- Truncation (default): duty = pending[PRECISION-1 -: PWM_BITS].
- Compare: pwm_out <= (next pwm_cnt < duty). Duty 0 gives a constant 0. Duty 2^PWM_BITS-1 gives high for (2^PWM_BITS-1)/2^PWM_BITS of the frame. Never constantly high.
- Reset values: pwm_out 0, frame_start 0, underrun 0, duty 0, pwm_cnt 0, prescaler 0, pending_full 0 (so sample_ready = 1).
- Reset mid-frame: all state is cleared immediately and the pending sample is discarded. The first frame after release starts at pwm_cnt 0.

## Timing
- Frame length = PRESCALE × 2^PWM_BITS clk cycles.
- frame_start and pwm_out are registered. Both change in the cycle after the `tick` that moves pwm_cnt to 0.
- Latency from sample acceptance to effect on pwm_out: up to the next frame boundary + 1 cycle.
- sample_ready drops in the cycle after acceptance. It rises in the cycle after the boundary that consumes pending.
- Throughput: one sample per frame.

## Configuration
- SINE_PWM_ERRFB_EN defined: first-order error feedback.
  - Residual register r, PRECISION-PWM_BITS bits, reset to 0.
  - At a load: ext = pending + r, computed PRECISION+1 bits wide.
  - duty = min(ext >> (PRECISION-PWM_BITS), 2^PWM_BITS-1).
  - r = low PRECISION-PWM_BITS bits of ext.
  - Underrun frames leave r unchanged.
- SINE_PWM_ERRFB_EN not defined: plain truncation and no residual register.
- When PRECISION == PWM_BITS the macro has no effect.

## Structure
- Package sine_pwm_pkg holds:
  - the parameter legality check (PWM_BITS ≤ PRECISION, PRESCALE ≥ 1);
  - the localparam for residual width;
  - the duty saturation function.
- Sub-module tick_prescaler (parameter PRESCALE; ports clk, rst, tick) generates the step strobe and is reused by other PWM-driven blocks.

## Test plan
All scenarios use PRECISION=8, PWM_BITS=4, PRESCALE=2, so each frame is 32 clk cycles.
- Reset: hold rst 3 cycles, then release. Required: pwm_out=0, frame_start=0, underrun=0, sample_ready=1, and the first frame_start 32 cycles after release.
- Single sample 0x80 accepted in frame 0. Required: frame 1 has pwm_out high for exactly 16 of 32 cycles, and frame_start repeats every 32 cycles.
- Samples 0x00 then 0xFF, one per frame. Required: pwm_out low for all 32 cycles of the first frame, then high for 30 of 32 cycles of the next.
- Backpressure: present 0x40 and 0xC0 back-to-back. Required: sample_ready=0 after the first is accepted until the boundary, the second is accepted the cycle after, and duties are 4 then 12.
- Underrun: one sample, then sample_valid=0. Required: an underrun pulse at every following boundary, and the duty of the last sample is held.
- Error feedback: constant 0x08 with the macro defined. Required: duty alternates 0,1,0,1 across frames. Without the macro, duty stays 0 and pwm_out stays low.
- Reset mid-frame: assert rst at cycle 10 of a duty-8 frame. Required: pwm_out=0 immediately, pending discarded, and sample_ready=1 after release.
